// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: the format-select encoding
// and the raw instruction width.
package imm_pkg;

   localparam int INSTR_WIDTH = 32;

   typedef enum logic [2:0] {
      IMM_I       = 3'b000,
      IMM_S       = 3'b001,
      IMM_B       = 3'b010,
      IMM_U       = 3'b011,
      IMM_J       = 3'b100,
      IMM_SHAMT   = 3'b101,
      IMM_ZIMM    = 3'b110,
      IMM_ILLEGAL = 3'b111
   } imm_src_e;

   // shamt, zimm and the illegal encoding never inherit Instr[31] above bit 31
   function automatic logic is_zero_ext(input imm_src_e src);
      return src inside {IMM_SHAMT, IMM_ZIMM, IMM_ILLEGAL};
   endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute immediate bus: input handshake with instruction and tag, output
// handshake with the extended immediate. The generator is the slave.
interface imm_gen_pipe_if
   import imm_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int IMM_SRC_WIDTH = 3,
   parameter int TAG_WIDTH     = 32
) ();

   logic                     InValid;
   logic                     InReady;
   logic [INSTR_WIDTH-1:0]   Instr;
   logic [IMM_SRC_WIDTH-1:0] ImmSrc;
   logic [TAG_WIDTH-1:0]     InTag;

   logic                     OutValid;
   logic                     OutReady;
   logic [DATA_WIDTH-1:0]    ImmOp;
   logic [TAG_WIDTH-1:0]     OutTag;
   logic                     IllegalImm;

   modport master (
      output InValid, Instr, ImmSrc, InTag, OutReady,
      input  InReady, OutValid, ImmOp, OutTag, IllegalImm
   );

   modport slave (
      input  InValid, Instr, ImmSrc, InTag, OutReady,
      output InReady, OutValid, ImmOp, OutTag, IllegalImm
   );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction for all RV32I/RV64I formats plus shamt and zimm,
// extended to DATA_WIDTH.
module imm_decode
   import imm_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [INSTR_WIDTH-1:0] Instr_i,
   input  imm_src_e               ImmSrc_i,
   output logic [DATA_WIDTH-1:0]  ImmOp_o,
   output logic                   IllegalImm_o
);

   logic [31:0] imm32;
   logic        unusedOpcode;

   assign unusedOpcode = ^Instr_i[6:0];

   // Build the low 32 bits first, then widen by sign or zero fill
   always_comb begin
      imm32        = '0;
      IllegalImm_o = 1'b0;
      case (ImmSrc_i)
         IMM_I:       imm32 = {{20{Instr_i[31]}}, Instr_i[31:20]};
         IMM_S:       imm32 = {{20{Instr_i[31]}}, Instr_i[31:25], Instr_i[11:7]};
         IMM_B:       imm32 = {{20{Instr_i[31]}}, Instr_i[7], Instr_i[30:25],
                               Instr_i[11:8], 1'b0};
         IMM_U:       imm32 = {Instr_i[31:12], 12'b0};
         IMM_J:       imm32 = {{12{Instr_i[31]}}, Instr_i[19:12], Instr_i[20],
                               Instr_i[30:21], 1'b0};
         IMM_SHAMT: begin
            imm32 = {26'b0, Instr_i[25:20]};
            if (DATA_WIDTH == 32) begin
               imm32[5] = 1'b0;
            end
         end
         IMM_ZIMM:    imm32 = {27'b0, Instr_i[19:15]};
         IMM_ILLEGAL: IllegalImm_o = 1'b1;
         default:     IllegalImm_o = 1'b1;
      endcase

      ImmOp_o        = is_zero_ext(ImmSrc_i) ? '0 : {DATA_WIDTH{imm32[31]}};
      ImmOp_o[31:0]  = imm32;
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes on input transfer and holds results in an
// output register backed by a one-entry skid register for execute-side backpressure.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int IMM_SRC_WIDTH = 3,
   parameter int TAG_WIDTH     = 32
) (
   input logic           clk,
   input logic           rst_n,
   input logic           Flush,
   imm_gen_pipe_if.slave bus
);

   logic [IMM_SRC_WIDTH-1:0] immSrc;
   logic [DATA_WIDTH-1:0]    decImm;
   logic                     decIllegal;

   logic                     orValid_q, orValid_d;
   logic                     srValid_q, srValid_d;
   logic                     inReady_q;
   logic [DATA_WIDTH-1:0]    orImm_q, srImm_q;
   logic [TAG_WIDTH-1:0]     orTag_q, srTag_q;
   logic                     orIllegal_q, srIllegal_q;

   logic                     inXfer, outXfer, orLoadIn, srLoad, srToOr;

   assign immSrc = bus.ImmSrc;

   imm_decode #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_decode (
      .Instr_i      (bus.Instr),
      .ImmSrc_i     (imm_src_e'(immSrc)),
      .ImmOp_o      (decImm),
      .IllegalImm_o (decIllegal)
   );

   // Flush suppresses every load; SR is only ever valid while OR is valid
   always_comb begin
      inXfer    = bus.InValid & inReady_q;
      outXfer   = orValid_q & bus.OutReady;
      srToOr    = srValid_q & bus.OutReady & ~Flush;
      orLoadIn  = inXfer & (~orValid_q | bus.OutReady) & ~Flush;
      srLoad    = inXfer & orValid_q & ~bus.OutReady & ~Flush;

      orValid_d = orValid_q;
      srValid_d = srValid_q;
      if (Flush) begin
         orValid_d = 1'b0;
         srValid_d = 1'b0;
      end else begin
         if (srToOr || orLoadIn) begin
            orValid_d = 1'b1;
         end else if (outXfer) begin
            orValid_d = 1'b0;
         end
         if (srToOr) begin
            srValid_d = 1'b0;
         end else if (srLoad) begin
            srValid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         orValid_q <= 1'b0;
         srValid_q <= 1'b0;
         inReady_q <= 1'b1;
      end else begin
         orValid_q <= orValid_d;
         srValid_q <= srValid_d;
         inReady_q <= ~srValid_d;
      end
   end

   // Reset to zero so the output bus reads clean straight out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         orImm_q     <= '0;
         orTag_q     <= '0;
         orIllegal_q <= 1'b0;
      end else if (srToOr) begin
         orImm_q     <= srImm_q;
         orTag_q     <= srTag_q;
         orIllegal_q <= srIllegal_q;
      end else if (orLoadIn) begin
         orImm_q     <= decImm;
         orTag_q     <= bus.InTag;
         orIllegal_q <= decIllegal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         srImm_q     <= '0;
         srTag_q     <= '0;
         srIllegal_q <= 1'b0;
      end else if (srLoad) begin
         srImm_q     <= decImm;
         srTag_q     <= bus.InTag;
         srIllegal_q <= decIllegal;
      end
   end

   assign bus.InReady    = inReady_q;
   assign bus.OutValid   = orValid_q;
   assign bus.ImmOp      = orImm_q;
   assign bus.OutTag     = orTag_q;
   assign bus.IllegalImm = orIllegal_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: 32-bit and 64-bit instances, hand-computed immediates,
// backpressure, flush and asynchronous reset.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.DATA_WIDTH(32), .IMM_SRC_WIDTH(3), .TAG_WIDTH(32)) bus32 ();
   imm_gen_pipe_if #(.DATA_WIDTH(64), .IMM_SRC_WIDTH(3), .TAG_WIDTH(32)) bus64 ();

   imm_gen_pipe #(.DATA_WIDTH(32), .IMM_SRC_WIDTH(3), .TAG_WIDTH(32)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .Flush (flush),
      .bus   (bus32)
   );

   imm_gen_pipe #(.DATA_WIDTH(64), .IMM_SRC_WIDTH(3), .TAG_WIDTH(32)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .Flush (flush),
      .bus   (bus64)
   );

   logic [31:0] b2bInstr [8] = '{32'hFE512E23, 32'hFE000CE3, 32'h123450B7, 32'h001000EF,
                                 32'h02005013, 32'hFFFF8073, 32'hFFFFFFFF, 32'h01F05013};
   logic [2:0]  b2bSrc   [8] = '{3'b001, 3'b010, 3'b011, 3'b100,
                                 3'b101, 3'b110, 3'b111, 3'b101};
   logic [31:0] b2bImm   [8] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800,
                                 32'h00000000, 32'h0000001F, 32'h00000000, 32'h0000001F};
   logic        b2bIll   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   logic [31:0] w64Instr [5] = '{32'hFFF00093, 32'h02005013, 32'h800000B7, 32'h001000EF,
                                 32'hFFFF8073};
   logic [2:0]  w64Src   [5] = '{3'b000, 3'b101, 3'b011, 3'b100, 3'b110};
   logic [63:0] w64Imm   [5] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000020,
                                 64'hFFFFFFFF80000000, 64'h0000000000000800,
                                 64'h000000000000001F};

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                input logic [2:0] src, input logic [31:0] tag);
      bus32.InValid = valid;
      bus32.Instr   = instr;
      bus32.ImmSrc  = src;
      bus32.InTag   = tag;
   endtask

   task automatic applyStimulus64(input logic valid, input logic [31:0] instr,
                                  input logic [2:0] src, input logic [31:0] tag);
      bus64.InValid = valid;
      bus64.Instr   = instr;
      bus64.ImmSrc  = src;
      bus64.InTag   = tag;
   endtask

   task automatic checkBus32(input string tag, input logic valid, input logic [31:0] imm,
                             input logic [31:0] otag, input logic illegal);
      checkOutput({tag, ".OutValid"}, {63'b0, bus32.OutValid}, {63'b0, valid});
      if (valid) begin
         checkOutput({tag, ".ImmOp"}, {32'b0, bus32.ImmOp}, {32'b0, imm});
         checkOutput({tag, ".OutTag"}, {32'b0, bus32.OutTag}, {32'b0, otag});
         checkOutput({tag, ".IllegalImm"}, {63'b0, bus32.IllegalImm}, {63'b0, illegal});
      end
   endtask

   task automatic checkReady32(input string tag, input logic ready);
      checkOutput({tag, ".InReady"}, {63'b0, bus32.InReady}, {63'b0, ready});
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
      applyStimulus64(1'b0, 32'h0, 3'b000, 32'h0);
      bus32.OutReady = 1'b1;
      bus64.OutReady = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      checkReady32("rst", 1'b1);
      checkOutput("rst.OutValid", {63'b0, bus32.OutValid}, 64'h0);
      checkOutput("rst.ImmOp", {32'b0, bus32.ImmOp}, 64'h0);
      checkOutput("rst.OutTag", {32'b0, bus32.OutTag}, 64'h0);
      checkOutput("rst.IllegalImm", {63'b0, bus32.IllegalImm}, 64'h0);
      checkOutput("rst64.ImmOp", bus64.ImmOp, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single I-type, one cycle latency
      applyStimulus(1'b1, 32'hFFF00093, 3'b000, 32'h0000_0040);
      @(negedge clk);
      checkBus32("itype", 1'b1, 32'hFFFFFFFF, 32'h0000_0040, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      checkBus32("itype.drain", 1'b0, 32'h0, 32'h0, 1'b0);

      // Back-to-back formats, one output per cycle
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, b2bInstr[i], b2bSrc[i], 32'h1000 + 32'(i * 4));
         @(negedge clk);
         checkBus32($sformatf("b2b[%0d]", i), 1'b1, b2bImm[i], 32'h1000 + 32'(i * 4), b2bIll[i]);
      end
      applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      checkBus32("b2b.drain", 1'b0, 32'h0, 32'h0, 1'b0);

      // Backpressure: two accepted, third refused, FIFO order with stable outputs
      bus32.OutReady = 1'b0;
      applyStimulus(1'b1, 32'h00500093, 3'b000, 32'h100);
      checkReady32("stall.a", 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 32'hFFF00093, 3'b000, 32'h104);
      checkReady32("stall.b", 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 32'hABCDE037, 3'b011, 32'h108);
      checkReady32("stall.c", 1'b0);
      @(negedge clk);
      checkBus32("stall.hold1", 1'b1, 32'h00000005, 32'h100, 1'b0);
      checkReady32("stall.hold1", 1'b0);
      @(negedge clk);
      checkBus32("stall.hold2", 1'b1, 32'h00000005, 32'h100, 1'b0);
      bus32.OutReady = 1'b1;
      @(negedge clk);
      checkBus32("stall.outB", 1'b1, 32'hFFFFFFFF, 32'h104, 1'b0);
      checkReady32("stall.outB", 1'b1);
      @(negedge clk);
      checkBus32("stall.outC", 1'b1, 32'hABCDE000, 32'h108, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      checkBus32("stall.empty", 1'b0, 32'h0, 32'h0, 1'b0);

      // Flush with both entries full, then flush dropping an offered input
      bus32.OutReady = 1'b0;
      applyStimulus(1'b1, 32'h00100093, 3'b000, 32'h200);
      @(negedge clk);
      applyStimulus(1'b1, 32'h00200093, 3'b000, 32'h204);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
      checkReady32("flush.full", 1'b0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkBus32("flush.full", 1'b0, 32'h0, 32'h0, 1'b0);
      checkReady32("flush.full.after", 1'b1);
      bus32.OutReady = 1'b1;
      flush = 1'b1;
      applyStimulus(1'b1, 32'h00300093, 3'b000, 32'h208);
      @(negedge clk);
      flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
      checkBus32("flush.drop", 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checkBus32("flush.drop2", 1'b0, 32'h0, 32'h0, 1'b0);

      // Asynchronous reset mid-stream, then a fresh one-cycle transfer
      bus32.OutReady = 1'b0;
      applyStimulus(1'b1, 32'h00700093, 3'b000, 32'h300);
      @(negedge clk);
      applyStimulus(1'b1, 32'h00800093, 3'b000, 32'h304);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
      checkBus32("midrst.full", 1'b1, 32'h00000007, 32'h300, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst.OutValid", {63'b0, bus32.OutValid}, 64'h0);
      checkOutput("midrst.InReady", {63'b0, bus32.InReady}, 64'h1);
      checkOutput("midrst.ImmOp", {32'b0, bus32.ImmOp}, 64'h0);
      checkOutput("midrst.OutTag", {32'b0, bus32.OutTag}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus32.OutReady = 1'b1;
      applyStimulus(1'b1, 32'hFFF00093, 3'b000, 32'h400);
      checkReady32("postrst", 1'b1);
      @(negedge clk);
      checkBus32("postrst", 1'b1, 32'hFFFFFFFF, 32'h400, 1'b0);
      applyStimulus(1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      checkBus32("postrst.drain", 1'b0, 32'h0, 32'h0, 1'b0);

      // 64-bit instance: sign extension to bit 63 and full 6-bit shamt
      for (int i = 0; i < 5; i++) begin
         applyStimulus64(1'b1, w64Instr[i], w64Src[i], 32'h500 + 32'(i));
         @(negedge clk);
         checkOutput($sformatf("w64[%0d].OutValid", i), {63'b0, bus64.OutValid}, 64'h1);
         checkOutput($sformatf("w64[%0d].ImmOp", i), bus64.ImmOp, w64Imm[i]);
         checkOutput($sformatf("w64[%0d].OutTag", i), {32'b0, bus64.OutTag},
                     {32'b0, 32'h500 + 32'(i)});
      end
      applyStimulus64(1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
